// File: rtl/tmr_regfile_scrub_pkg.sv
// Shared types and constants for the triplicated register file scrubber.
// Contents: FSM state enum, address width, error counter width/saturation.
package tmr_regfile_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCRUB_CHK = 2'd1,
    SCRUB_FIX = 2'd2
  } state_t;

  localparam int unsigned ADDR_W = 4;

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/tmr_regfile_scrubber_majority_voter.sv
// Bitwise 2-of-3 majority vote across three copies of a word.
// Ports: a, b, c - the three copies; vote_c - combinational voted word.
module majority_voter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote_c
);

  assign vote_c = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_regfile_scrubber.sv
// Triplicated register file with voted host reads and a background scrubber
// that rewrites entries whose three copies disagree.
// Ports: clk/rstn; host request (req_valid/ready/we/addr/wdata) with
// registered read response (rsp_valid/rsp_rdata); scrub_en gates the scrub
// interval counter; inj_* flips bits in one copy; scrub_busy flags an active
// scrub step; err_count counts corrected entries (saturating).
module tmr_regfile_scrubber
  import tmr_regfile_scrub_pkg::*;
#(
  parameter int unsigned DEPTH          = 14,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SCRUB_INTERVAL = 16,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  input  logic              scrub_en,
  input  logic              inj_valid,
  input  logic [1:0]        inj_copy,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [WIDTH-1:0]  inj_mask,
  output logic              scrub_busy,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_LIMIT);

  state_t state, state_nx;

  logic [WIDTH-1:0]  mem   [3][DEPTH];
  logic [WIDTH-1:0]  mem_d [3][DEPTH];
  logic [ADDR_W-1:0] scrub_addr;
  logic [CNT_W-1:0]  int_cnt;
  logic              scrub_pending;
  logic [STV_W-1:0]  starve_cnt;

  logic              starve_full;
  logic              host_acc;
  logic              host_in_range;
  logic              host_we;
  logic [ADDR_W-1:0] rd_idx;
  logic [WIDTH-1:0]  rd_vote;
  logic [WIDTH-1:0]  scrub_vote;
  logic              mismatch;
  logic              scrub_grant;
  logic              fix_we;
  logic              scrub_adv;

  assign starve_full   = (starve_cnt == STV_LIMIT);
  assign req_ready     = (state == IDLE) && !(scrub_pending && starve_full);
  assign scrub_busy    = (state != IDLE);
  assign host_acc      = req_valid && req_ready;
  assign host_in_range = (req_addr <= LAST_ADDR);
  assign host_we       = host_acc && req_we && host_in_range;
  // Out-of-range reads still need a legal index; their data is zeroed below.
  assign rd_idx        = host_in_range ? req_addr : '0;
  assign mismatch      = (mem[0][scrub_addr] != mem[1][scrub_addr]) ||
                         (mem[1][scrub_addr] != mem[2][scrub_addr]);

  majority_voter #(.WIDTH(WIDTH)) u_vote_rd (
    .a(mem[0][rd_idx]), .b(mem[1][rd_idx]), .c(mem[2][rd_idx]), .vote_c(rd_vote)
  );

  majority_voter #(.WIDTH(WIDTH)) u_vote_scrub (
    .a(mem[0][scrub_addr]), .b(mem[1][scrub_addr]), .c(mem[2][scrub_addr]),
    .vote_c(scrub_vote)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (scrub_grant) state_nx = SCRUB_CHK;
      SCRUB_CHK: state_nx = mismatch ? SCRUB_FIX : IDLE;
      SCRUB_FIX: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Control decode; a starved scrub wins even with a host request present.
  always_comb begin
    scrub_grant = 1'b0;
    fix_we      = 1'b0;
    scrub_adv   = 1'b0;
    case (state)
      IDLE:      scrub_grant = scrub_pending && (!req_valid || starve_full);
      SCRUB_CHK: scrub_adv   = !mismatch;
      SCRUB_FIX: begin
        fix_we    = 1'b1;
        scrub_adv = 1'b1;
      end
      default: ;
    endcase
  end

  // Next array contents: host/scrub write first, injection flips on top.
  always_comb begin
    mem_d = mem;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (host_we && (req_addr == ADDR_W'(i)))  mem_d[k][i] = req_wdata;
        if (fix_we && (scrub_addr == ADDR_W'(i))) mem_d[k][i] = scrub_vote;
        if (inj_valid && (inj_copy == 2'(k)) && (inj_addr == ADDR_W'(i)))
          mem_d[k][i] = mem_d[k][i] ^ inj_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < int'(DEPTH); i++)
          mem[k][i] <= '0;
    end else begin
      mem <= mem_d;
    end
  end

  // Read response pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= host_acc && !req_we;
      if (host_acc && !req_we) rsp_rdata <= host_in_range ? rd_vote : '0;
    end
  end

  // Scrub scheduling: interval counter, pending flag, starvation count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_cnt       <= '0;
      scrub_pending <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      if (scrub_en) int_cnt <= (int_cnt == CNT_LAST) ? '0 : int_cnt + CNT_W'(1);
      if (scrub_en && (int_cnt == CNT_LAST)) scrub_pending <= 1'b1;
      else if (scrub_grant)                  scrub_pending <= 1'b0;
      if (scrub_grant)                       starve_cnt <= '0;
      else if (host_acc && scrub_pending)    starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Scrub walk pointer and corrected-entry counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scrub_addr <= '0;
      err_count  <= '0;
    end else begin
      if (scrub_adv) scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + ADDR_W'(1);
      if (fix_we && (err_count != ERR_MAX)) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
